receptor_notas_tom: RTL

Note-playback receiver for the 3-bit note code the datapath drives to the Arduino (`arduino_out`). It decodes that code into an audible square wave on a local buzzer pin, so the board can play notes without the external microcontroller. It synchronizes and glitch-filters the code and generates the tone with a per-note frequency divider. A minimum-play timer keeps short notes audible.

---
 rtl/receptor_notas_tom.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/receptor_notas_tom.sv
// Note-playback receiver: synchronizes and debounces a 3-bit note code and
// drives a buzzer with a per-note square wave, sustaining short notes.
module receptor_notas_tom #(
  parameter int CLK_HZ          = 50000000,
  parameter int STABLE_CYCLES   = 4,
  parameter int MIN_PLAY_CYCLES = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] nota_in,
  input  logic       habilita,
  output logic       buzzer,
  output logic       tocando,
  output logic [2:0] nota_atual,
  output logic       nova_nota,
  output logic [1:0] db_estado
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = (MIN_PLAY_CYCLES > 0) ? $clog2(MIN_PLAY_CYCLES + 1) : 1;
  localparam logic [CW-1:0] STABLE_T = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] MIN_T    = TW'(MIN_PLAY_CYCLES);

  typedef enum logic [1:0] {
    SILENCIO = 2'd0,
    TOCANDO  = 2'd1,
    SUSTENTA = 2'd2
  } estado_t;

  estado_t state, state_next;
  logic          load;
  logic [2:0]    sync1, sync2, prev, aceito;
  logic [CW-1:0] stable_cnt, stable_next;
  logic [23:0]   div, half_cur;
  logic          phase;
  logic [TW-1:0] timer;
  logic          expired;

  function automatic logic [23:0] half_of(input logic [2:0] n);
    case (n)
      3'd1:    half_of = 24'(CLK_HZ / (2 * 262));
      3'd2:    half_of = 24'(CLK_HZ / (2 * 294));
      3'd3:    half_of = 24'(CLK_HZ / (2 * 330));
      3'd4:    half_of = 24'(CLK_HZ / (2 * 349));
      3'd5:    half_of = 24'(CLK_HZ / (2 * 392));
      3'd6:    half_of = 24'(CLK_HZ / (2 * 440));
      3'd7:    half_of = 24'(CLK_HZ / (2 * 494));
      default: half_of = 24'd1;
    endcase
  endfunction

  // Run length of the current synchronized code, saturating at STABLE_CYCLES.
  always_comb begin
    stable_next = stable_cnt;
    if (sync2 != prev)
      stable_next = CW'(1);
    else if (stable_cnt < STABLE_T)
      stable_next = stable_cnt + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      aceito     <= '0;
    end else begin
      sync1      <= nota_in;
      sync2      <= sync1;
      prev       <= sync2;
      stable_cnt <= stable_next;
      if (stable_next >= STABLE_T)
        aceito <= sync2;
    end
  end

  assign expired  = (timer >= MIN_T);
  assign half_cur = half_of(nota_atual);

  always_ff @(posedge clock) begin
    if (!reset)
      state <= SILENCIO;
    else
      state <= state_next;
  end

  // A different nonzero code always reloads, even when the timer expires.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      SILENCIO: begin
        if (aceito != 3'd0) begin
          load       = 1'b1;
          state_next = TOCANDO;
        end
      end
      TOCANDO: begin
        if (aceito != 3'd0 && aceito != nota_atual)
          load = 1'b1;
        else if (aceito == 3'd0)
          state_next = expired ? SILENCIO : SUSTENTA;
      end
      SUSTENTA: begin
        if (aceito != 3'd0 && aceito != nota_atual) begin
          load       = 1'b1;
          state_next = TOCANDO;
        end else if (expired)
          state_next = SILENCIO;
        else if (aceito == nota_atual)
          state_next = TOCANDO;
      end
      default: state_next = SILENCIO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      nota_atual <= '0;
      div        <= '0;
      phase      <= 1'b0;
      timer      <= '0;
      nova_nota  <= 1'b0;
    end else if (load) begin
      nota_atual <= aceito;
      div        <= '0;
      phase      <= 1'b1;
      timer      <= '0;
      nova_nota  <= 1'b1;
    end else begin
      nova_nota <= 1'b0;
      if (state_next == SILENCIO) begin
        nota_atual <= '0;
        div        <= '0;
        phase      <= 1'b0;
        timer      <= '0;
      end else begin
        if (div == half_cur - 24'd1) begin
          div   <= '0;
          phase <= ~phase;
        end else begin
          div <= div + 24'd1;
        end
        if (timer < MIN_T)
          timer <= timer + TW'(1);
      end
    end
  end

  assign buzzer    = phase & habilita;
  assign tocando   = (state != SILENCIO);
  assign db_estado = state;

endmodule
